// File: rtl/dcache_ctrl_if.sv
// Bundle of the pipeline-side and backing-memory-side signals of the data cache.
// The master modport is the environment (pipeline M-stage plus memory).
// The slave modport is the cache controller itself.
interface dcache_ctrl_if;
  // pipeline side
  logic        cpu_req;
  logic [3:0]  cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        data_ready;
  // backing-memory side
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    input  cpu_rdata, data_ready, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    output cpu_rdata, data_ready, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Blocking, write-through, no-write-allocate, direct-mapped data cache controller.
// Each line holds one 32-bit word. A read hit completes combinationally in IDLE.
// Misses and all stores go to backing memory through a req/ack handshake,
// and the access ends with a one-cycle RESP pulse.
module dcache_ctrl #(
  parameter int INDEX_W = 4
) (
  input  logic          clk,
  input  logic          rst,   // active-low, asynchronous
  dcache_ctrl_if.slave  bus
);
  localparam int TAG_W = 32 - 2 - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic        mem_req_q,   mem_req_d;
  logic        mem_we_q,    mem_we_d;
  logic [31:0] mem_addr_q,  mem_addr_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rdata_q,     rdata_d;

  // Lookup uses the live CPU address; the fill uses the latched word address so a
  // dropped request still lands in the right line.
  logic [INDEX_W-1:0] cpu_idx, fill_idx;
  logic [TAG_W-1:0]   cpu_tag, fill_tag;
  logic               hit, rd_hit, wr_hit, fill_done;
  logic [31:0]        merged_word;

  assign cpu_idx  = bus.cpu_addr[INDEX_W+1:2];
  assign cpu_tag  = bus.cpu_addr[31:INDEX_W+2];
  assign fill_idx = mem_addr_q[INDEX_W+1:2];
  assign fill_tag = mem_addr_q[31:INDEX_W+2];

  assign hit       = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
  assign rd_hit    = (state_q == IDLE) && bus.cpu_req && (bus.cpu_we == 4'b0000) && hit;
  assign wr_hit    = (state_q == IDLE) && bus.cpu_req && (bus.cpu_we != 4'b0000) && hit;
  assign fill_done = (state_q == FILL) && bus.mem_ack;

  // Byte-lane merge of the store data into the cached word.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      assign merged_word[8*gi +: 8] = bus.cpu_we[gi] ? bus.cpu_wdata[8*gi +: 8]
                                                     : data_q[cpu_idx][8*gi +: 8];
    end
  endgenerate

  // Next-state logic for the controller FSM and the memory-side request registers.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          if (bus.cpu_we == 4'b0000) begin
            if (!hit) begin
              state_d     = FILL;
              mem_req_d   = 1'b1;
              mem_we_d    = 1'b0;
              mem_addr_d  = {bus.cpu_addr[31:2], 2'b00};
              mem_wstrb_d = bus.cpu_we;
            end
          end else begin
            state_d     = WRITE;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = {bus.cpu_addr[31:2], 2'b00};
            mem_wstrb_d = bus.cpu_we;
            mem_wdata_d = bus.cpu_wdata;
          end
        end
      end
      FILL: begin
        if (bus.mem_ack) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          rdata_d   = bus.mem_rdata;
        end
      end
      WRITE: begin
        if (bus.mem_ack) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state and valid bits; reset drops mem_req immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wstrb_q <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      if (fill_done) begin
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays: refill on ack, store-hit merge in place.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      data_q[fill_idx] <= bus.mem_rdata;
      tag_q[fill_idx]  <= fill_tag;
    end else if (wr_hit) begin
      data_q[cpu_idx]  <= merged_word;
    end
  end

  assign bus.data_ready = rd_hit || (state_q == RESP);
  assign bus.cpu_rdata  = rd_hit ? data_q[cpu_idx] : rdata_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wstrb  = mem_wstrb_q;
  assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: stimulus pushes the expected response word,
// a negedge monitor pops it whenever data_ready is seen.
module tb_dcache_ctrl;
  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;
  logic [31:0] exp_q[$];

  dcache_ctrl_if bus ();

  dcache_ctrl #(.INDEX_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Response monitor: every data_ready pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (rst && bus.data_ready) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_ready: got data_ready=1 rdata=%h expected no response", bus.cpu_rdata);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        $display("resp rdata=%h expected=%h", bus.cpu_rdata, e);
        chk("resp_rdata", bus.cpu_rdata, e);
      end
    end
  end

  // One access, called and returning at posedge+1. to_mem: access goes to memory.
  task automatic access(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wdata,
                        input bit to_mem, input int lat, input logic [31:0] fill,
                        input logic [31:0] exp_rd);
    $display("txn addr=%h we=%b wdata=%h mem=%0d lat=%0d exp_rdata=%h", addr, we, wdata, to_mem, lat, exp_rd);
    exp_q.push_back(exp_rd);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    @(posedge clk); #1;
    if (!to_mem) begin
      chk("hit_no_mem_req", {31'd0, bus.mem_req}, 32'd0);
    end else begin
      for (int c = 1; c <= lat; c++) begin
        chk("mem_req_held", {31'd0, bus.mem_req}, 32'd1);
        if (c == 1) begin
          chk("mem_we", {31'd0, bus.mem_we}, {31'd0, (we != 4'b0000)});
          chk("mem_addr", bus.mem_addr, {addr[31:2], 2'b00});
          chk("mem_wstrb", {28'd0, bus.mem_wstrb}, {28'd0, we});
          if (we != 4'b0000) chk("mem_wdata", bus.mem_wdata, wdata);
        end
        if (c == lat) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = fill;
        end
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
      end
      chk("mem_req_dropped", {31'd0, bus.mem_req}, 32'd0);
      @(posedge clk); #1;
    end
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 4'b0000;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    rst = 1'b0;
    bus.cpu_req = 1'b0;
    bus.cpu_we = 4'b0000;
    bus.cpu_addr = 32'd0;
    bus.cpu_wdata = 32'd0;
    bus.mem_rdata = 32'd0;
    bus.mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_data_ready", {31'd0, bus.data_ready}, 32'd0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // miss with 3-cycle ack, then hit
    access(32'h0000_0040, 4'b0000, 32'd0,           1, 3, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    access(32'h0000_0040, 4'b0000, 32'd0,           0, 0, 32'd0,         32'hDEAD_BEEF);
    // store hit merges low half; register keeps last fill word
    access(32'h0000_0040, 4'b0011, 32'h0000_1234,   1, 1, 32'd0,         32'hDEAD_BEEF);
    access(32'h0000_0040, 4'b0000, 32'd0,           0, 0, 32'd0,         32'hDEAD_1234);
    // store miss does not allocate
    access(32'h0000_0080, 4'b1111, 32'h55AA_55AA,   1, 2, 32'd0,         32'hDEAD_BEEF);
    access(32'h0000_0080, 4'b0000, 32'd0,           1, 1, 32'h55AA_55AA, 32'h55AA_55AA);
    // same-index conflicts: every access refills
    access(32'h0000_0040, 4'b0000, 32'd0,           1, 2, 32'h1111_0040, 32'h1111_0040);
    access(32'h0000_0440, 4'b0000, 32'd0,           1, 1, 32'h2222_0440, 32'h2222_0440);
    access(32'h0000_0040, 4'b0000, 32'd0,           1, 1, 32'h3333_0040, 32'h3333_0040);
    // back-to-back hit right after RESP
    access(32'h0000_0040, 4'b0000, 32'd0,           0, 0, 32'd0,         32'h3333_0040);

    // reset two cycles into a fill
    $display("txn reset during fill addr=00000044");
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 4'b0000;
    bus.cpu_addr = 32'h0000_0044;
    @(posedge clk); #1;
    chk("rstfill_req_up", {31'd0, bus.mem_req}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.cpu_req = 1'b0;
    #1;
    chk("rstfill_req_async", {31'd0, bus.mem_req}, 32'd0);
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("late_ack_no_ready", {31'd0, bus.data_ready}, 32'd0);
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    chk("late_ack_no_req", {31'd0, bus.mem_req}, 32'd0);
    access(32'h0000_0040, 4'b0000, 32'd0,           1, 1, 32'h4444_0040, 32'h4444_0040);

    // cpu_req dropped during a fill: fill and RESP still happen
    $display("txn drop cpu_req during fill addr=00000048");
    exp_q.push_back(32'h5555_0048);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 4'b0000;
    bus.cpu_addr = 32'h0000_0048;
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    chk("drop_req_up", {31'd0, bus.mem_req}, 32'd1);
    @(posedge clk); #1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h5555_0048;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    chk("drop_req_down", {31'd0, bus.mem_req}, 32'd0);
    @(posedge clk); #1;
    access(32'h0000_0048, 4'b0000, 32'd0,           0, 0, 32'd0,         32'h5555_0048);

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Blocking, write-through, no-write-allocate, direct-mapped data cache controller that answers the pipeline's M-stage loads/stores and returns `data_ready`. It responds on the pipeline side, where the pipeline controller initiates: the pipeline holds `waiting`/`stall` until `data_ready` returns. It initiates on the backing-memory side with a req/ack handshake. Lines are one 32-bit word; tag, valid and data arrays are flops.

## Interface
- `INDEX_W`, default 4: index bits; the cache has 2^INDEX_W lines.
- `TAG_W`, default 32-2-INDEX_W: tag width, derived and never overridden.
- `clk`  in  1  sole clock; rising edge.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `cpu_req`  in  1  M-stage access valid, either load or store.
- `cpu_we`  in  4  byte write enables (the M-stage `dm_w_en` encoding); 4'b0000 means read.
- `cpu_addr`  in  32  byte address. Bits [1:0] are ignored. Index is [INDEX_W+1:2]; tag is [31:INDEX_W+2].
- `cpu_wdata`  in  32  store data, already lane-aligned.
- `cpu_rdata`  out  32  load word, valid when `data_ready` is 1.
- `data_ready`  out  1  access complete this cycle.
- `mem_req`  out  1  backing-memory request, held until ack.
- `mem_we`  out  1  1 = write, 0 = read.
- `mem_addr`  out  32  word address, with {cpu_addr[31:2],2'b00}.
- `mem_wstrb`  out  4  byte strobes; copy of `cpu_we`.
- `mem_wdata`  out  32  write data.
- `mem_rdata`  in  32  fill data, valid with `mem_ack`.
- `mem_ack`  in  1  one-cycle completion pulse. Ignored when `mem_req` is 0.

## Operation
- States: IDLE, FILL, WRITE, RESP.
- Pipeline contract: while `data_ready` is 0, the pipeline holds `cpu_req`/`cpu_we`/`cpu_addr`/`cpu_wdata` stable.
- IDLE, `cpu_req` with `cpu_we` = 0 and a hit (valid[idx] and tag match):
  - combinational `data_ready` = 1 and `cpu_rdata` = data[idx];
  - state stays IDLE.
- IDLE, read miss:
  - latch the word address;
  - go to FILL with `mem_req` = 1 and `mem_we` = 0.
- FILL:
  - hold `mem_req` and all mem_* outputs;
  - on `mem_ack`, write data[idx] = `mem_rdata`, tag[idx] = tag, valid[idx] = 1;
  - register `cpu_rdata` = `mem_rdata`;
  - go to RESP.
- IDLE, `cpu_req` with `cpu_we` ≠ 0:
  - on a hit, merge the enabled bytes into data[idx] at this edge;
  - on a miss, leave the arrays untouched (no allocate);
  - go to WRITE with `mem_req` = 1, `mem_we` = 1, `mem_wstrb` = `cpu_we`, `mem_wdata` = `cpu_wdata`.
- WRITE: hold; on `mem_ack`, go to RESP.
- RESP:
  - `data_ready` = 1 for exactly one cycle; `cpu_rdata` holds its registered value (the fill word, or unchanged after a store);
  - next state is IDLE unconditionally;
  - a new request is not evaluated in RESP.
- `cpu_req` = 0 in IDLE: no action, `data_ready` = 0.
- `cpu_req` dropping during FILL/WRITE:
  - the transaction still completes and the line is still filled;
  - the RESP pulse still occurs and is ignored upstream.
- In IDLE, a read hit drives `cpu_rdata` combinationally from the array; in every other state, from the register.

## Timing
- Reset values:
  - state IDLE, all valid bits 0;
  - `mem_req` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wstrb` = 0, `mem_wdata` = 0;
  - `cpu_rdata` register = 0, `data_ready` = 0;
  - tag/data arrays need no reset.
- Reset mid-FILL/WRITE:
  - `mem_req` drops immediately (asynchronous);
  - a late `mem_ack` after release is ignored because `mem_req` = 0.
- Read hit: `data_ready` in the same cycle as `cpu_req`; zero stall.
- Miss or store, with the request seen at edge E0:
  - `mem_req` is 1 from E0 until the edge that samples `mem_ack`, edge Ek;
  - RESP occupies the cycle after Ek;
  - stall = k+1 cycles; minimum 2 (ack in the first FILL/WRITE cycle).
- Back-to-back: after RESP, IDLE evaluates the next request one cycle later. A hit in that cycle completes immediately.
- Index conflict: a miss to an occupied index overwrites that line on fill. A store hit merges in place before the memory write completes.

## Test plan
- Reset, then read 0x0000_0040 (miss), ack after 3 cycles with 0xDEAD_BEEF:
  - `mem_req` is 1 for 3 cycles, then `data_ready` pulses with `cpu_rdata` = 0xDEAD_BEEF;
  - a repeat read hits with `data_ready` in the same cycle and no `mem_req`.
- After that fill, store `cpu_we` = 4'b0011, `cpu_wdata` = 0x0000_1234 to 0x40, ack after 1 cycle:
  - `mem_wstrb` = 0011;
  - `data_ready` in the 2nd cycle;
  - the next read hits and returns 0xDEAD_1234.
- Store to uncached 0x0000_0080: memory write is issued; a following read of 0x80 misses, proving no allocate.
- Read 0x40, then read 0x0000_0440 (same index at INDEX_W = 4, different tag), then read 0x40 again:
  - every access misses and each refills;
  - `cpu_rdata` tracks `mem_rdata`.
- Pull `rst` low two cycles into a FILL:
  - `mem_req` goes to 0 immediately;
  - after release, a read of 0x40 misses (valid cleared);
  - an ack asserted while `mem_req` = 0 causes no `data_ready`.
- Drop `cpu_req` during a FILL: the fill completes, the RESP pulse occurs, and a later read of the same address hits.
